// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
//   Shared constants for the scanning N:1 multiplexer.
//
//   W_DEFAULT      default data width per channel
//   N_DEFAULT      default channel count
//   DWELL_DEFAULT  default number of enabled cycles spent on each channel
//                  in auto-scan mode
//   sel_width(n)   width of a channel index for n channels,
//                  max(1, ceil(log2(n)))
// ---------------------------------------------------------------------------
package mux_pkg;

  localparam int W_DEFAULT     = 4;
  localparam int N_DEFAULT     = 4;
  localparam int DWELL_DEFAULT = 4;

  // Never returns less than 1, so a one-bit field is still produced for
  // counts of 1 or 2.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// ---------------------------------------------------------------------------
// mux_scan_ctr
//   Auto-scan sequencer: keeps the scan index and the dwell counter and
//   produces the registered wrap pulse.
//
//   Parameters
//     N        channel count (2..64)
//     DWELL    enabled cycles per channel (>= 1)
//   Ports
//     clk      rising-edge clock
//     rstb     asynchronous active-low reset, clears index, dwell and wrap
//     run      auto mode is capturing this cycle; advance the scan
//     restart  first auto capture after entering auto mode; the scan is
//              taken from channel 0 with a fresh dwell, without a wrap
//     idx      channel to be captured this cycle (valid while run = 1)
//     wrap     one-cycle pulse, registered alongside the capture that
//              shows channel 0 after channel N-1
// ---------------------------------------------------------------------------
module mux_scan_ctr
  import mux_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int DWELL    = DWELL_DEFAULT,
  localparam int SELW    = sel_width(N),
  localparam int DCW     = sel_width(DWELL)
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            run,
  input  logic            restart,
  output logic [SELW-1:0] idx,
  output logic            wrap
);

  localparam logic [SELW-1:0] IDX_LAST  = SELW'(N - 1);
  localparam logic [DCW-1:0]  DCNT_LAST = DCW'(DWELL - 1);

  // idx_reg/dcnt_reg describe the *next* capture: which channel it takes
  // and how many of that channel's dwell cycles have already been spent.
  logic [SELW-1:0] idx_reg;
  logic [SELW-1:0] idx_next;
  logic [DCW-1:0]  dcnt_reg;
  logic [DCW-1:0]  dcnt_next;
  logic            wrap_reg;
  logic            wrap_next;

  // Position actually used for this cycle's capture. On entry into auto
  // mode the held position is discarded in favour of channel 0, dwell 0.
  logic [SELW-1:0] base_idx;
  logic [DCW-1:0]  base_dcnt;

  always_comb begin
    base_idx  = restart ? '0 : idx_reg;
    base_dcnt = restart ? '0 : dcnt_reg;
    idx_next  = base_idx;
    dcnt_next = base_dcnt;
    wrap_next = 1'b0;

    if (run) begin
      if (base_dcnt == DCNT_LAST) begin
        dcnt_next = '0;
        idx_next  = (base_idx == IDX_LAST) ? '0 : base_idx + SELW'(1);
      end else begin
        dcnt_next = base_dcnt + DCW'(1);
      end
      // A held position of (0,0) that is not a fresh entry can only have
      // been reached by rolling over from channel N-1: that is a new pass.
      // Reset leaves (0,0) too, but the top always flags the first auto
      // capture after reset as a restart, which masks this.
      wrap_next = ~restart & (idx_reg == '0) & (dcnt_reg == '0);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      idx_reg  <= '0;
      dcnt_reg <= '0;
      wrap_reg <= 1'b0;
    end else begin
      idx_reg  <= idx_next;
      dcnt_reg <= dcnt_next;
      wrap_reg <= wrap_next;
    end
  end

  assign idx  = base_idx;
  assign wrap = wrap_reg;

endmodule

// File: rtl/mux_scan_nx1.sv
// ---------------------------------------------------------------------------
// mux_scan_nx1
//   Registered N:1 multiplexer with a manual select mode and an auto-scan
//   mode that walks the channels 0..N-1, DWELL enabled cycles each.
//
//   Parameters
//     W        data width per channel (>= 1)
//     N        channel count (2..64, any value)
//     DWELL    enabled cycles per channel in auto-scan mode (>= 1)
//   Ports
//     clk        rising-edge clock
//     rstb       asynchronous active-low reset
//     data       packed channels, channel k at [k*W +: W]
//     sel_in     manual channel select
//     mode       0 = manual, 1 = auto-scan
//     enable     1 = capture, 0 = freeze out/out_sel and the scan position
//     out        registered channel data (0 for an illegal manual select)
//     out_sel    channel index associated with out
//     out_valid  out was captured from a legal channel on the last edge
//     wrap       one-cycle pulse at the start of each new auto-scan pass
// ---------------------------------------------------------------------------
module mux_scan_nx1
  import mux_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int N      = N_DEFAULT,
  parameter int DWELL  = DWELL_DEFAULT,
  localparam int SELW  = sel_width(N)
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic [N*W-1:0]  data,
  input  logic [SELW-1:0] sel_in,
  input  logic            mode,
  input  logic            enable,
  output logic [W-1:0]    out,
  output logic [SELW-1:0] out_sel,
  output logic            out_valid,
  output logic            wrap
);

  // The select space is padded up to a power of two so any select value
  // indexes a defined entry; the padding entries read as zero.
  localparam int              NSLOT = 1 << SELW;
  localparam logic [SELW:0]   N_EXT = (SELW + 1)'(N);

  logic [W-1:0] chan [NSLOT];

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_chan
      if (gi < N) begin : g_live
        assign chan[gi] = data[gi*W +: W];
      end else begin : g_pad
        assign chan[gi] = '0;
      end
    end
  endgenerate

  // Mode of the most recent enabled cycle. Only enabled cycles count, so
  // toggling mode while frozen does not by itself restart the scan.
  logic mode_prev_reg;

  logic            run;
  logic            restart;
  logic [SELW-1:0] scan_idx;

  assign run     = enable & mode;
  assign restart = enable & mode & ~mode_prev_reg;

  mux_scan_ctr #(
    .N     (N),
    .DWELL (DWELL)
  ) u_ctr (
    .clk     (clk),
    .rstb    (rstb),
    .run     (run),
    .restart (restart),
    .idx     (scan_idx),
    .wrap    (wrap)
  );

  logic [SELW-1:0] cap_sel;
  logic            cap_legal;

  // The scan index is always in range; a manual select must be checked.
  assign cap_sel   = mode ? scan_idx : sel_in;
  assign cap_legal = mode | ({1'b0, sel_in} < N_EXT);

  logic [W-1:0]    out_reg;
  logic [SELW-1:0] out_sel_reg;
  logic            out_valid_reg;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mode_prev_reg <= 1'b0;
      out_reg       <= '0;
      out_sel_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else if (enable) begin
      mode_prev_reg <= mode;
      out_reg       <= cap_legal ? chan[cap_sel] : '0;
      out_sel_reg   <= cap_sel;
      out_valid_reg <= cap_legal;
    end else begin
      // Frozen: data and index hold, but nothing new was captured.
      out_valid_reg <= 1'b0;
    end
  end

  assign out       = out_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_nx1
//   Two instances: u_dut0 (W=4, N=4, DWELL=4) and u_dut1 (W=4, N=3,
//   DWELL=2) share every input except that u_dut1 sees the low 12 data bits.
//   A reference model tracks, per instance, the number of enabled auto
//   cycles since entering auto mode and derives channel and wrap from it.
// ---------------------------------------------------------------------------
module tb_mux_scan_nx1;

  logic        clk = 1'b0;
  logic        rstb;
  logic [15:0] data;
  logic [1:0]  sel_in;
  logic        mode;
  logic        enable;

  logic [3:0]  out0, out1;
  logic [1:0]  osel0, osel1;
  logic        v0, v1, w0, w1;

  always #5 clk = ~clk;

  mux_scan_nx1 #(.W(4), .N(4), .DWELL(4)) u_dut0 (
    .clk       (clk),
    .rstb      (rstb),
    .data      (data),
    .sel_in    (sel_in),
    .mode      (mode),
    .enable    (enable),
    .out       (out0),
    .out_sel   (osel0),
    .out_valid (v0),
    .wrap      (w0)
  );

  mux_scan_nx1 #(.W(4), .N(3), .DWELL(2)) u_dut1 (
    .clk       (clk),
    .rstb      (rstb),
    .data      (data[11:0]),
    .sel_in    (sel_in),
    .mode      (mode),
    .enable    (enable),
    .out       (out1),
    .out_sel   (osel1),
    .out_valid (v1),
    .wrap      (w1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  int nn [2] = '{4, 3};
  int dd [2] = '{4, 2};
  int m_out [2];
  int m_sel [2];
  int m_valid [2];
  int m_wrap [2];
  int m_pos [2];    // enabled auto cycles since entering auto mode
  int m_mlast [2];  // mode of the last enabled cycle

  function automatic int chan_val(input int k);
    return int'((data >> (4 * k)) & 16'hF);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_out[d] = 0; m_sel[d] = 0; m_valid[d] = 0; m_wrap[d] = 0;
      m_pos[d] = 0; m_mlast[d] = 0;
    end
  endtask

  task automatic model_step();
    int s;
    s = int'(sel_in);
    for (int d = 0; d < 2; d++) begin
      if (enable) begin
        if (mode) begin
          int ch;
          bit fresh;
          fresh = (m_mlast[d] == 0);
          if (fresh) m_pos[d] = 0;
          ch = (m_pos[d] / dd[d]) % nn[d];
          m_out[d]   = chan_val(ch);
          m_sel[d]   = ch;
          m_valid[d] = 1;
          m_wrap[d]  = (!fresh && (m_pos[d] % (nn[d] * dd[d]) == 0)) ? 1 : 0;
          m_pos[d]++;
          m_mlast[d] = 1;
        end else begin
          m_out[d]   = (s < nn[d]) ? chan_val(s) : 0;
          m_sel[d]   = s;
          m_valid[d] = (s < nn[d]) ? 1 : 0;
          m_wrap[d]  = 0;
          m_mlast[d] = 0;
        end
      end else begin
        m_valid[d] = 0;
        m_wrap[d]  = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".d0.out"},   int'(out0),  m_out[0]);
    chk({tag, ".d0.sel"},   int'(osel0), m_sel[0]);
    chk({tag, ".d0.valid"}, int'(v0),    m_valid[0]);
    chk({tag, ".d0.wrap"},  int'(w0),    m_wrap[0]);
    chk({tag, ".d1.out"},   int'(out1),  m_out[1]);
    chk({tag, ".d1.sel"},   int'(osel1), m_sel[1]);
    chk({tag, ".d1.valid"}, int'(v1),    m_valid[1]);
    chk({tag, ".d1.wrap"},  int'(w1),    m_wrap[1]);
  endtask

  // One transaction: drive inputs, step model, let one edge pass, compare.
  task automatic cycle(input int s, input int m, input int e, input string tag);
    sel_in = 2'(s);
    mode   = 1'(m);
    enable = 1'(e);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
    $display("%s t=%0t sel=%0d mode=%0d en=%0d data=%h | d0 out=%0d sel=%0d v=%0d w=%0d | d1 out=%0d sel=%0d v=%0d w=%0d",
             tag, $time, s, m, e, data, out0, osel0, v0, w0, out1, osel1, v1, w1);
  endtask

  // Reset pulse asserted away from any clock edge; outputs must clear
  // before the next edge arrives.
  task automatic reset_pulse(input string tag);
    #2;
    rstb = 1'b0;
    #1;
    chk({tag, ".async.d0.out"},   int'(out0),  0);
    chk({tag, ".async.d0.sel"},   int'(osel0), 0);
    chk({tag, ".async.d0.valid"}, int'(v0),    0);
    chk({tag, ".async.d0.wrap"},  int'(w0),    0);
    chk({tag, ".async.d1.out"},   int'(out1),  0);
    chk({tag, ".async.d1.sel"},   int'(osel1), 0);
    chk({tag, ".async.d1.valid"}, int'(v1),    0);
    model_reset();
    @(posedge clk);
    #1;
    chk({tag, ".held.d0.out"}, int'(out0), 0);
    $display("%s t=%0t reset pulse", tag, $time);
    rstb = 1'b1;
  endtask

  typedef struct {
    int sel;
    int en;
    int e0_out, e0_sel, e0_v;
    int e1_out, e1_sel, e1_v;
  } vec_t;

  vec_t tbl [6];

  int exp_ch [4] = '{1, 2, 4, 8};

  initial begin
    rstb = 1'b1; data = 16'h8421; sel_in = '0; mode = 1'b0; enable = 1'b0;
    model_reset();

    // Manual values on the outputs first, so the reset clear is visible.
    #1;
    cycle(1, 0, 1, "pre");
    cycle(1, 0, 1, "pre");
    chk("pre.d0.out", int'(out0), 2);
    reset_pulse("rst");

    // Manual select table (mode 0)
    tbl[0] = '{0, 1, 1, 0, 1, 1, 0, 1};
    tbl[1] = '{1, 1, 2, 1, 1, 2, 1, 1};
    tbl[2] = '{2, 1, 4, 2, 1, 4, 2, 1};
    tbl[3] = '{3, 1, 8, 3, 1, 0, 3, 0};
    tbl[4] = '{0, 0, 8, 3, 0, 0, 3, 0};
    tbl[5] = '{2, 1, 4, 2, 1, 4, 2, 1};
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].sel, 0, tbl[i].en, "man");
      chk($sformatf("man%0d.d0.out", i),   int'(out0),  tbl[i].e0_out);
      chk($sformatf("man%0d.d0.sel", i),   int'(osel0), tbl[i].e0_sel);
      chk($sformatf("man%0d.d0.valid", i), int'(v0),    tbl[i].e0_v);
      chk($sformatf("man%0d.d1.out", i),   int'(out1),  tbl[i].e1_out);
      chk($sformatf("man%0d.d1.sel", i),   int'(osel1), tbl[i].e1_sel);
      chk($sformatf("man%0d.d1.valid", i), int'(v1),    tbl[i].e1_v);
    end

    // Data change between edges must not reach out.
    data = 16'h1248;
    #2;
    chk("comb.d0.out", int'(out0), 4);
    cycle(2, 0, 1, "comb");
    chk("comb.next.d0.out", int'(out0), 2);
    data = 16'h8421;

    // Auto scan from manual: 1x4, 2x4, 4x4, 8x4, then 1 with wrap.
    for (int c = 0; c < 20; c++) begin
      cycle(0, 1, 1, "auto");
      chk($sformatf("auto%0d.d0.out", c),  int'(out0),  exp_ch[(c / 4) % 4]);
      chk($sformatf("auto%0d.d0.sel", c),  int'(osel0), (c / 4) % 4);
      chk($sformatf("auto%0d.d0.wrap", c), int'(w0),    (c == 16) ? 1 : 0);
    end

    // Freeze mid-dwell on channel 2, then finish its dwell.
    cycle(0, 0, 1, "re");
    for (int c = 0; c < 10; c++) cycle(0, 1, 1, "dw");
    chk("dw.d0.out", int'(out0), 4);
    for (int c = 0; c < 3; c++) begin
      cycle(0, 1, 0, "frz");
      chk($sformatf("frz%0d.d0.out", c),   int'(out0),  4);
      chk($sformatf("frz%0d.d0.sel", c),   int'(osel0), 2);
      chk($sformatf("frz%0d.d0.valid", c), int'(v0),    0);
    end
    for (int c = 0; c < 2; c++) begin
      cycle(0, 1, 1, "res");
      chk($sformatf("res%0d.d0.out", c),   int'(out0), 4);
      chk($sformatf("res%0d.d0.valid", c), int'(v0),   1);
    end
    cycle(0, 1, 1, "ch3");
    chk("ch3.d0.out", int'(out0), 8);
    cycle(0, 1, 1, "ch3");

    // Reset while on channel 3: restart at 0 with full dwell, no wrap.
    reset_pulse("mid");
    for (int c = 0; c < 5; c++) begin
      cycle(0, 1, 1, "post");
      chk($sformatf("post%0d.d0.out", c),  int'(out0), (c < 4) ? 1 : 2);
      chk($sformatf("post%0d.d0.wrap", c), int'(w0),   0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int m;
      data = 16'($urandom);
      m = ($urandom_range(0, 15) == 0) ? int'(!mode) : int'(mode);
      cycle(int'($urandom_range(0, 3)), m, ($urandom_range(0, 5) != 0) ? 1 : 0, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
